// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers.
// Imported by the timing generator and its axis counters.
package vga_pkg;

   typedef struct packed {
      int active;
      int front;
      int sync;
      int back;
   } vga_axis_t;

   localparam int COLOR_W_DEF = 4;

   localparam vga_axis_t VGA640_H  = '{active: 640, front: 16, sync: 96,  back: 48};
   localparam vga_axis_t VGA640_V  = '{active: 480, front: 10, sync: 2,   back: 33};
   localparam vga_axis_t SVGA800_H = '{active: 800, front: 40, sync: 128, back: 88};
   localparam vga_axis_t SVGA800_V = '{active: 600, front: 1,  sync: 4,   back: 23};

   function automatic int axis_total(input int active, input int front,
                                     input int sync, input int back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one VGA axis.
// wrap flags the last position so the next axis can be chained.
module vga_axis_counter #(
   parameter int TOTAL = 800,
   parameter int W     = $clog2(TOTAL)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   assign wrap = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator on sys_clk with pixel strobe.
// Issues look-ahead pixel requests and registers HS/VS/DE/RGB.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = VGA640_H.active,
   parameter int   H_FRONT  = VGA640_H.front,
   parameter int   H_SYNC   = VGA640_H.sync,
   parameter int   H_BACK   = VGA640_H.back,
   parameter int   V_ACTIVE = VGA640_V.active,
   parameter int   V_FRONT  = VGA640_V.front,
   parameter int   V_SYNC   = VGA640_V.sync,
   parameter int   V_BACK   = VGA640_V.back,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   COLOR_W  = COLOR_W_DEF,
   parameter int   REQ_LAT  = 1,
   localparam int  H_TOTAL  = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
   localparam int  V_TOTAL  = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
   localparam int  CW       = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL)
) (
   input  logic                 sys_clk,
   input  logic                 vga_rst_n,
   input  logic                 pix_ce,
   input  logic [3*COLOR_W-1:0] pixel_data,
   output logic                 pixel_req,
   output logic [CW-1:0]        pixel_xpos,
   output logic [CW-1:0]        pixel_ypos,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic                 vga_de,
   output logic [3*COLOR_W-1:0] vga_rgb,
   output logic                 line_start,
   output logic                 frame_start
);

   if (REQ_LAT < 1 || REQ_LAT > H_SYNC + H_BACK) begin : g_bad_lat
      $fatal(1, "vga_timing_gen: REQ_LAT out of range");
   end
   if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
       V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_porch
      $fatal(1, "vga_timing_gen: porch/sync width of zero");
   end

   localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
   localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
   localparam logic [CW-1:0] H_ACT0   = CW'(H_SYNC + H_BACK);
   localparam logic [CW-1:0] H_ACT1   = CW'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [CW-1:0] V_ACT0   = CW'(V_SYNC + V_BACK);
   localparam logic [CW-1:0] V_ACT1   = CW'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [CW-1:0] H_REQ0   = CW'(H_SYNC + H_BACK - REQ_LAT);
   localparam logic [CW-1:0] H_REQ1   = CW'(H_SYNC + H_BACK + H_ACTIVE - REQ_LAT);

   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic          h_wrap;
   logic          v_wrap_unused;
   logic          h_act;
   logic          v_act;
   logic          h_req;
   logic          de_nxt;

   vga_axis_counter #(.TOTAL(H_TOTAL), .W(CW)) u_h_cnt (
      .clk   (sys_clk),
      .rst_n (vga_rst_n),
      .en    (pix_ce),
      .cnt   (h_cnt),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(.TOTAL(V_TOTAL), .W(CW)) u_v_cnt (
      .clk   (sys_clk),
      .rst_n (vga_rst_n),
      .en    (pix_ce & h_wrap),
      .cnt   (v_cnt),
      .wrap  (v_wrap_unused)
   );

   assign h_act  = (h_cnt >= H_ACT0) && (h_cnt < H_ACT1);
   assign v_act  = (v_cnt >= V_ACT0) && (v_cnt < V_ACT1);
   assign h_req  = (h_cnt >= H_REQ0) && (h_cnt < H_REQ1);
   assign de_nxt = h_act && v_act;

   // Request runs REQ_LAT strobes ahead of the displayed column.
   always_comb begin
      pixel_req  = v_act && h_req;
      pixel_xpos = '0;
      pixel_ypos = '0;
      if (pixel_req) begin
         pixel_xpos = h_cnt - H_REQ0;
         pixel_ypos = v_cnt - V_ACT0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!vga_rst_n) begin
         vga_hs      <= ~HS_POL;
         vga_vs      <= ~VS_POL;
         vga_de      <= 1'b0;
         vga_rgb     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_ce && (h_cnt == '0);
         frame_start <= pix_ce && (h_cnt == '0) && (v_cnt == '0);
         if (pix_ce) begin
            vga_hs  <= (h_cnt < H_SYNC_C) ? HS_POL : ~HS_POL;
            vga_vs  <= (v_cnt < V_SYNC_C) ? VS_POL : ~VS_POL;
            vga_de  <= de_nxt;
            vga_rgb <= de_nxt ? pixel_data : '0;
         end
      end
   end

endmodule
